// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: default register
// addresses, status word bit positions and the TX state encoding.
package mmio_pkg;

    localparam logic [31:0] TX_ADDR_DEF     = 32'h1001_0024;
    localparam logic [31:0] STATUS_ADDR_DEF = 32'h1001_0028;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Small circular byte FIFO with wrapping pointers and an occupancy counter.
// A pop while full frees a slot, so a push in the same cycle is accepted.
module byte_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic push_ok;
    logic pop_ok;

    assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    // Combinational read so the FSM can load the shifter on the pop edge.
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter on the core's data bus: stores to the TX register are
// queued in a byte FIFO and sent 8N1, LSB first; the status register is read-only.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int          CLK_DIV     = 434,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] TX_ADDR     = TX_ADDR_DEF,
    parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Selected,
    output logic        Tx
);
    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;

    logic       tx_sel, stat_sel, push, stat_rd, pop;
    logic       fifo_full, fifo_empty, busy, baud_done;
    logic [7:0] fifo_dout;
    logic       unused_wdata_hi;

    assign tx_sel          = (Address == TX_ADDR);
    assign stat_sel        = (Address == STATUS_ADDR);
    assign Selected        = tx_sel || stat_sel;
    assign push            = MemWrite && tx_sel;
    assign stat_rd         = MemRead && stat_sel;
    assign busy            = (state_q != IDLE) || !fifo_empty;
    assign baud_done       = (baud_q == '0);
    assign Tx              = tx_q;
    assign unused_wdata_hi = ^WriteData[31:8];

    byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        ReadData = '0;
        if (stat_rd) begin
            ReadData[STAT_FULL]  = fifo_full;
            ReadData[STAT_EMPTY] = fifo_empty;
            ReadData[STAT_BUSY]  = busy;
            ReadData[STAT_OVF]   = ovf_q;
        end
    end

    // A push that the FIFO refuses (full, no pop freeing a slot) wins over a clearing read.
    always_comb begin
        ovf_d = ovf_q;
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end else if (stat_rd) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    bit_d   = 3'd7;
                    baud_d  = DIV_M1;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = DIV_M1;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = DIV_M1;
                    if (bit_q == '0) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q - 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        bit_d   = 3'd7;
                        baud_d  = DIV_M1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised and directed checks of mmio_uart_tx against a frame-schedule model:
// each accepted byte owns a 10-bit frame starting at max(push+1, end of previous frame).
module tb_mmio_uart_tx;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int FRAME   = 10 * CLK_DIV;
    localparam logic [31:0] TXA   = 32'h1001_0024;
    localparam logic [31:0] STA   = 32'h1001_0028;
    localparam logic [31:0] OTHER = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] ReadData;
    logic        Selected;
    logic        Tx;

    mmio_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH),
        .TX_ADDR    (TXA),
        .STATUS_ADDR(STA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Selected  (Selected),
        .Tx        (Tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         p;
        int         s;
        logic [7:0] d;
    } frame_t;

    frame_t fq[$];
    int     last_end = 0;
    logic   m_ovf = 1'b0;
    int     cyc = 0;
    int     asserts = 0;
    int     fails = 0;

    logic [31:0] rd_obs, rd_exp;
    logic        sel_obs, sel_exp, tx_obs, tx_exp;

    // Bytes held in the FIFO after edge k.
    function automatic int m_count(input int k);
        int c = 0;
        foreach (fq[i]) if (fq[i].p <= k && fq[i].s > k) c++;
        return c;
    endfunction

    function automatic logic [31:0] m_status(input int k);
        logic busy = 1'b0;
        int   c = m_count(k);
        foreach (fq[i]) if (fq[i].p <= k && k < fq[i].s + FRAME) busy = 1'b1;
        return {28'b0, m_ovf, busy, (c == 0), (c == DEPTH)};
    endfunction

    function automatic logic m_tx(input int k);
        foreach (fq[i]) begin
            if (fq[i].s <= k && k < fq[i].s + FRAME) begin
                int idx = (k - fq[i].s) / CLK_DIV;
                if (idx == 0) return 1'b0;
                if (idx == 9) return 1'b1;
                return fq[i].d[idx-1];
            end
        end
        return 1'b1;
    endfunction

    task automatic m_edge(input int n, input logic psh, input logic [7:0] d, input logic srd);
        int   c = m_count(n - 1);
        logic popping = 1'b0;
        logic acc;
        foreach (fq[i]) if (fq[i].s == n) popping = 1'b1;
        acc = psh && (c < DEPTH || popping);
        if (acc) begin
            int s = (n + 1 > last_end) ? n + 1 : last_end;
            fq.push_back('{p: n, s: s, d: d});
            last_end = s + FRAME;
        end
        if (psh && !acc) m_ovf = 1'b1;
        else if (srd)    m_ovf = 1'b0;
    endtask

    task automatic m_clear();
        fq.delete();
        last_end = 0;
        m_ovf = 1'b0;
    endtask

    // One bus cycle, entered and left at a falling edge; records observed and modelled values.
    task automatic do_cycle(input logic we, input logic re, input logic [31:0] addr, input logic [7:0] wd);
        MemWrite  = we;
        MemRead   = re;
        Address   = addr;
        WriteData = {24'($urandom), wd};
        #1;
        rd_obs  = ReadData;
        sel_obs = Selected;
        rd_exp  = (re && addr == STA) ? m_status(cyc) : 32'h0;
        sel_exp = (addr == TXA) || (addr == STA);
        @(posedge clk);
        cyc++;
        m_edge(cyc, we && (addr == TXA), wd, re && (addr == STA));
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        tx_obs = Tx;
        tx_exp = m_tx(cyc);
    endtask

    task automatic test_reset();
        do_cycle(1'b0, 1'b1, STA, 8'h00);
        asserts++;
        if (rd_obs !== 32'h2) begin
            fails++;
            $display("FAIL reset_status: got %h expected %h", rd_obs, 32'h2);
        end
        asserts++;
        if (tx_obs !== 1'b1) begin
            fails++;
            $display("FAIL reset_tx: got %b expected 1", tx_obs);
        end
    endtask

    task automatic test_single();
        logic [9:0] seq = 10'b11_0100_1010;
        do_cycle(1'b1, 1'b0, TXA, 8'hA5);
        for (int i = 1; i <= 44; i++) begin
            logic re = (i == 10) || (i == 42);
            do_cycle(1'b0, re, STA, 8'h00);
            asserts++;
            if (tx_obs !== tx_exp) begin
                fails++;
                $display("FAIL single_tx cyc %0d: got %b expected %b", i, tx_obs, tx_exp);
            end
            if (i <= 40 && (i - 1) % CLK_DIV == 0) begin
                asserts++;
                if (tx_obs !== seq[(i-1)/CLK_DIV]) begin
                    fails++;
                    $display("FAIL single_bit %0d: got %b expected %b", (i-1)/CLK_DIV, tx_obs, seq[(i-1)/CLK_DIV]);
                end
            end
            if (re) begin
                asserts++;
                if (rd_obs !== ((i == 10) ? 32'h6 : 32'h2) || rd_obs !== rd_exp) begin
                    fails++;
                    $display("FAIL single_status cyc %0d: got %h expected %h", i, rd_obs, rd_exp);
                end
            end
        end
    endtask

    task automatic test_burst5();
        for (int b = 1; b <= 5; b++) do_cycle(1'b1, 1'b0, TXA, 8'(b));
        do_cycle(1'b0, 1'b1, STA, 8'h00);
        asserts++;
        if (rd_obs !== 32'h5) begin
            fails++;
            $display("FAIL burst5_status: got %h expected %h", rd_obs, 32'h5);
        end
        for (int i = 0; i < 5 * FRAME + 2; i++) begin
            do_cycle(1'b0, 1'b0, OTHER, 8'h00);
            asserts++;
            if (tx_obs !== tx_exp) begin
                fails++;
                $display("FAIL burst5_tx cyc %0d: got %b expected %b", cyc, tx_obs, tx_exp);
            end
        end
    endtask

    task automatic test_overflow();
        for (int b = 0; b < 6; b++) do_cycle(1'b1, 1'b0, TXA, 8'(8'h10 + b));
        do_cycle(1'b0, 1'b1, STA, 8'h00);
        asserts++;
        if (rd_obs !== 32'hD) begin
            fails++;
            $display("FAIL ovf_set: got %h expected %h", rd_obs, 32'hD);
        end
        do_cycle(1'b0, 1'b1, STA, 8'h00);
        asserts++;
        if (rd_obs !== 32'h5) begin
            fails++;
            $display("FAIL ovf_clear: got %h expected %h", rd_obs, 32'h5);
        end
        for (int i = 0; i < 5 * FRAME + 4; i++) begin
            logic re = (i % 17 == 0);
            do_cycle(1'b0, re, STA, 8'h00);
            asserts++;
            if (tx_obs !== tx_exp || rd_obs !== rd_exp || (re && rd_obs[3] !== 1'b0)) begin
                fails++;
                $display("FAIL ovf_drain cyc %0d: tx %b/%b status %h/%h", cyc, tx_obs, tx_exp, rd_obs, rd_exp);
            end
        end
    endtask

    task automatic test_full_pop_push();
        int base = fq.size();
        int first_s;
        for (int b = 0; b < 5; b++) do_cycle(1'b1, 1'b0, TXA, 8'(8'h60 + b));
        first_s = fq[base].s;
        for (int i = 0; i < 2 * FRAME && cyc < first_s + FRAME - 1; i++) begin
            do_cycle(1'b0, 1'b0, OTHER, 8'h00);
        end
        asserts++;
        if (cyc !== first_s + FRAME - 1) begin
            fails++;
            $display("FAIL fullpop_align: cyc %0d expected %0d", cyc, first_s + FRAME - 1);
        end
        do_cycle(1'b1, 1'b0, TXA, 8'h3C);
        do_cycle(1'b0, 1'b1, STA, 8'h00);
        asserts++;
        if (rd_obs !== 32'h5) begin
            fails++;
            $display("FAIL fullpop_status: got %h expected %h", rd_obs, 32'h5);
        end
        for (int i = 0; i < 6 * FRAME && cyc <= last_end + 1; i++) begin
            do_cycle(1'b0, 1'b0, OTHER, 8'h00);
            asserts++;
            if (tx_obs !== tx_exp) begin
                fails++;
                $display("FAIL fullpop_tx cyc %0d: got %b expected %b", cyc, tx_obs, tx_exp);
            end
        end
    endtask

    task automatic test_decode();
        do_cycle(1'b0, 1'b1, TXA, 8'h00);
        asserts++;
        if (rd_obs !== 32'h0 || sel_obs !== 1'b1) begin
            fails++;
            $display("FAIL decode_txload: rd %h sel %b expected 0 and 1", rd_obs, sel_obs);
        end
        do_cycle(1'b0, 1'b1, OTHER, 8'h00);
        asserts++;
        if (rd_obs !== 32'h0 || sel_obs !== 1'b0) begin
            fails++;
            $display("FAIL decode_other: rd %h sel %b expected 0 and 0", rd_obs, sel_obs);
        end
        do_cycle(1'b1, 1'b0, STA, 8'h77);
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b0, 1'b0, OTHER, 8'h00);
            asserts++;
            if (tx_obs !== 1'b1) begin
                fails++;
                $display("FAIL decode_statstore_tx: got %b expected 1", tx_obs);
            end
        end
        do_cycle(1'b0, 1'b1, STA, 8'h00);
        asserts++;
        if (rd_obs !== 32'h2) begin
            fails++;
            $display("FAIL decode_statstore_status: got %h expected %h", rd_obs, 32'h2);
        end
    endtask

    task automatic test_reset_mid();
        do_cycle(1'b1, 1'b0, TXA, 8'h00);
        do_cycle(1'b1, 1'b0, TXA, 8'h00);
        for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b0, OTHER, 8'h00);
        asserts++;
        if (tx_obs !== 1'b0) begin
            fails++;
            $display("FAIL midreset_pre_tx: got %b expected 0", tx_obs);
        end
        #2 reset = 1'b0;
        #1;
        asserts++;
        if (Tx !== 1'b1) begin
            fails++;
            $display("FAIL midreset_async_tx: got %b expected 1", Tx);
        end
        @(negedge clk);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b1;
        m_clear();
        do_cycle(1'b0, 1'b1, STA, 8'h00);
        asserts++;
        if (rd_obs !== 32'h2 || tx_obs !== 1'b1) begin
            fails++;
            $display("FAIL midreset_status: got %h tx %b expected %h tx 1", rd_obs, tx_obs, 32'h2);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            logic        we = ($urandom_range(0, 9) < 3);
            logic        re = ($urandom_range(0, 9) < 3);
            int          a  = $urandom_range(0, 3);
            logic [31:0] addr = (a <= 1) ? TXA : ((a == 2) ? STA : OTHER);
            do_cycle(we, re, addr, 8'($urandom));
            asserts++;
            if (tx_obs !== tx_exp || rd_obs !== rd_exp || sel_obs !== sel_exp) begin
                fails++;
                $display("FAIL random cyc %0d: tx %b/%b rd %h/%h sel %b/%b", cyc, tx_obs, tx_exp, rd_obs, rd_exp, sel_obs, sel_exp);
            end
        end
        for (int i = 0; i < 6 * FRAME && cyc <= last_end + 1; i++) begin
            do_cycle(1'b0, 1'b1, STA, 8'h00);
            asserts++;
            if (tx_obs !== tx_exp || rd_obs !== rd_exp) begin
                fails++;
                $display("FAIL random_drain cyc %0d: tx %b/%b rd %h/%h", cyc, tx_obs, tx_exp, rd_obs, rd_exp);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_clear();
        test_reset();
        test_single();
        test_burst5();
        test_overflow();
        test_full_pop_push();
        test_decode();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
